fetch_unit: RTL and testbench

Instruction-fetch stage of the RTypeProcessor. It owns the program counter, drives the `PC` input of `instr_mem`, and samples the combinational `instrCode` it returns into the IF/ID pipeline register consumed by the decoder. It supports pipeline stall, flush and taken-branch redirect, and keeps a count of fetched instructions.

---
 rtl/fetch_unit_if.sv | 43 ++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, the instruction memory and the decoder.
// The master side is the fetch unit; the slave side is its surroundings.
interface fetch_unit_if;
  logic [31:0] PC;
  logic [31:0] instrCode;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  modport master (
    output PC,
    input  instrCode,
    input  stall,
    input  flush,
    input  branch_taken,
    input  branch_target,
    output if_id_pc,
    output if_id_instr,
    output if_id_valid,
    output misalign_err,
    output fetch_count
  );

  modport slave (
    input  PC,
    output instrCode,
    output stall,
    output flush,
    output branch_taken,
    output branch_target,
    input  if_id_pc,
    input  if_id_instr,
    input  if_id_valid,
    input  misalign_err,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register and fetch counter,
// with stall, flush and branch redirect handling behind a one-cycle boot phase.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_BOOT  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        misalign_err_q, misalign_err_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_RESET;
      pc_q           <= RESET_PC;
      if_id_pc_q     <= 32'h0000_0000;
      if_id_instr_q  <= NOP_INSTR;
      if_id_valid_q  <= 1'b0;
      misalign_err_q <= 1'b0;
      fetch_count_q  <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      if_id_pc_q     <= if_id_pc_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_valid_q  <= if_id_valid_d;
      misalign_err_q <= misalign_err_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  // Next-state logic; redirect beats flush beats stall beats normal fetch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    if_id_pc_d     = if_id_pc_q;
    if_id_instr_d  = if_id_instr_q;
    if_id_valid_d  = if_id_valid_q;
    misalign_err_d = 1'b0;
    fetch_count_d  = fetch_count_q;

    case (state_q)
      ST_RESET: begin
        state_d = ST_BOOT;
      end
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.branch_taken) begin
          pc_d           = {bus.branch_target[31:2], 2'b00};
          if_id_instr_d  = NOP_INSTR;
          if_id_valid_d  = 1'b0;
          misalign_err_d = is_misaligned(bus.branch_target);
        end else if (bus.flush) begin
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
          if (bus.stall) begin
            pc_d = pc_q;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else begin
          if_id_instr_d = bus.instrCode;
          if_id_pc_d    = pc_q;
          if_id_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  assign bus.PC           = pc_q;
  assign bus.if_id_pc     = if_id_pc_q;
  assign bus.if_id_instr  = if_id_instr_q;
  assign bus.if_id_valid  = if_id_valid_q;
  assign bus.misalign_err = misalign_err_q;
  assign bus.fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for the documented corner cases,
// then randomized traffic checked against a rule-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h0149_8333;
      32'h0000_0004: return 32'h006E_8393;
      32'h0000_0008: return 32'h40C5_8533;
      32'h0000_0040: return 32'h0020_8093;
      default:       return addr ^ 32'h5A5A_0003;
    endcase
  endfunction

  assign bus.instrCode = mem_word(bus.PC);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic valid,
                         input logic [31:0] instr, input logic [31:0] ifpc,
                         input logic mis, input logic [31:0] cnt);
    chk({tag, ".PC"}, bus.PC, pc);
    chk({tag, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, valid});
    chk({tag, ".instr"}, bus.if_id_instr, instr);
    chk({tag, ".if_id_pc"}, bus.if_id_pc, ifpc);
    chk({tag, ".misalign"}, {31'd0, bus.misalign_err}, {31'd0, mis});
    chk({tag, ".count"}, bus.fetch_count, cnt);
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic apply(input logic s, input logic f, input logic b, input logic [31:0] t);
    bus.stall         = s;
    bus.flush         = f;
    bus.branch_taken  = b;
    bus.branch_target = t;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic        mis;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[18];

  // Reference model state: edges since reset release, plus architectural outputs.
  int          m_phase;
  logic [31:0] m_pc, m_ifpc, m_instr, m_cnt;
  logic        m_valid, m_mis;

  function automatic void model_reset();
    m_phase = 0;
    m_pc    = 32'h0;
    m_ifpc  = 32'h0;
    m_instr = NOP;
    m_cnt   = 32'h0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
  endfunction

  function automatic void model_step(input logic s, input logic f, input logic b,
                                     input logic [31:0] t);
    m_mis = 1'b0;
    if (m_phase < 2) begin
      m_phase++;
    end else if (b) begin
      m_mis   = (t % 4) != 0;
      m_pc    = t - (t % 4);
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (f) begin
      m_valid = 1'b0;
      m_instr = NOP;
      if (!s) m_pc = m_pc + 32'd4;
    end else if (!s) begin
      m_instr = mem_word(m_pc);
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic s, f, b;
    logic [31:0] t;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h80,        32'h0,  1'b0, NOP,           32'h0,  1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h0,  1'b0, NOP,           32'h0,  1'b0, 32'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h4,  1'b1, 32'h0149_8333, 32'h0,  1'b0, 32'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8,  1'b1, 32'h006E_8393, 32'h4,  1'b0, 32'd2};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8,  1'b1, 32'h006E_8393, 32'h4,  1'b0, 32'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8,  1'b1, 32'h006E_8393, 32'h4,  1'b0, 32'd2};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hC,  1'b1, 32'h40C5_8533, 32'h8,  1'b0, 32'd3};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h10, 1'b0, NOP,           32'h8,  1'b0, 32'd3};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h10, 1'b0, NOP,           32'h8,  1'b0, 32'd3};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h40,        32'h40, 1'b0, NOP,           32'h8,  1'b0, 32'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h44, 1'b1, 32'h0020_8093, 32'h40, 1'b0, 32'd4};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h42,        32'h40, 1'b0, NOP,           32'h40, 1'b1, 32'd4};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h44, 1'b1, 32'h0020_8093, 32'h40, 1'b0, 32'd5};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, NOP,    32'h40, 1'b0, 32'd5};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 32'hFFFF_FFFC ^ 32'h5A5A_0003,
                32'hFFFF_FFFC, 1'b0, 32'd6};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h4,  1'b1, 32'h0149_8333, 32'h0,  1'b0, 32'd7};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 32'h13,        32'h10, 1'b0, NOP,           32'h0,  1'b1, 32'd7};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h14, 1'b1, 32'h10 ^ 32'h5A5A_0003, 32'h10, 1'b0, 32'd8};

    rst               = 1'b0;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 1'b0, NOP, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].stall, tbl[i].flush, tbl[i].br, tbl[i].tgt);
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].valid, tbl[i].instr,
              tbl[i].ifpc, tbl[i].mis, tbl[i].cnt);
    end

    // Mid-operation reset: outputs must clear with no clock edge in between.
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 1'b0, NOP, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    model_reset();
    model_step(1'b0, 1'b0, 1'b0, 32'h0);
    chk_all("rand_boot", m_pc, m_valid, m_instr, m_ifpc, m_mis, m_cnt);

    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) begin
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_all("rand_rst", m_pc, m_valid, m_instr, m_ifpc, m_mis, m_cnt);
        @(negedge clk);
        rst = 1'b1;
      end
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      end else begin
        t = 32'($urandom_range(0, 255));
      end
      apply(s, f, b, t);
      model_step(s, f, b, t);
      chk_all($sformatf("rand%0d", n), m_pc, m_valid, m_instr, m_ifpc, m_mis, m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
